// File: rtl/fp32_pipe_mul_if.sv
// Operand/result bundle for the FP32 pipelined multiplier.
// The bench (master) drives a and b; the multiplier (slave) returns out.
interface fp32_pipe_mul_if;
  localparam int unsigned WORD_W = 32;

  logic [WORD_W-1:0] a;
  logic [WORD_W-1:0] b;
  logic [WORD_W-1:0] out;

  modport master (output a, output b, input out);
  modport slave  (input a, input b, output out);
endinterface

// File: rtl/fp32_pipe_mul.sv
// fp32_pipe_mul: free-running FP32 multiplier, 11-cycle latency, 1 result/clock.
// The mantissa is truncated and the exponent wraps modulo 256.
// Build option FP32_MUL_SPECIAL_CASES_EN adds the NaN > Inf > zero output
// overrides. These are evaluated on raw operand words that travel alongside
// the data. Without the option the raw words are not carried at all.
module fp32_pipe_mul (
  input  logic           clk,
  input  logic           reset,
  fp32_pipe_mul_if.slave bus
);

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned EXP_W      = 8;
  localparam int unsigned MAN_W      = 23;
  localparam int unsigned SIG_W      = MAN_W + 1;
  localparam int unsigned PROD_W     = 2 * SIG_W;
  localparam int unsigned MUL_STAGES = 8;
  localparam int unsigned CHUNK_W    = SIG_W / MUL_STAGES;
  localparam int unsigned PP_W       = SIG_W + CHUNK_W;
  localparam int unsigned ESUM_W     = EXP_W + 2;

  // Stage 1: split fields of both operands.
  logic             sa_q, sa_d, sb_q, sb_d;
  logic [EXP_W-1:0] ea1_q, ea1_d, eb1_q, eb1_d;
  logic [MAN_W-1:0] ma1_q, ma1_d, mb1_q, mb1_d;

  // Multiplier pipe: index 0 is stage 2, index k is after k partial-product steps.
  logic [PROD_W-1:0] acc_q  [MUL_STAGES+1];
  logic [PROD_W-1:0] acc_d  [MUL_STAGES+1];
  logic              sign_q [MUL_STAGES+1];
  logic              sign_d [MUL_STAGES+1];
  logic [EXP_W-1:0]  ea_q   [MUL_STAGES+1];
  logic [EXP_W-1:0]  ea_d   [MUL_STAGES+1];
  logic [EXP_W-1:0]  eb_q   [MUL_STAGES+1];
  logic [EXP_W-1:0]  eb_d   [MUL_STAGES+1];
  logic [SIG_W-1:0]  siga_q [MUL_STAGES];
  logic [SIG_W-1:0]  siga_d [MUL_STAGES];
  logic [SIG_W-1:0]  sigb_q [MUL_STAGES];
  logic [SIG_W-1:0]  sigb_d [MUL_STAGES];

  // Final stage: normalised result fields.
  logic             sign_f_q, sign_f_d;
  logic [EXP_W-1:0] exp_f_q, exp_f_d;
  logic [MAN_W-1:0] man_f_q, man_f_d;
  logic [ESUM_W-1:0] exp_sum;

`ifdef FP32_MUL_SPECIAL_CASES_EN
  logic [WORD_W-1:0] rawa1_q, rawa1_d, rawb1_q, rawb1_d;
  logic [WORD_W-1:0] rawa_q [MUL_STAGES+1];
  logic [WORD_W-1:0] rawa_d [MUL_STAGES+1];
  logic [WORD_W-1:0] rawb_q [MUL_STAGES+1];
  logic [WORD_W-1:0] rawb_d [MUL_STAGES+1];
  logic [WORD_W-1:0] rawa_f_q, rawa_f_d, rawb_f_q, rawb_f_d;
`endif

  // Next-state for every pipeline stage; one 3-bit multiplier chunk per multiply step.
  always_comb begin
    sa_d  = bus.a[WORD_W-1];
    sb_d  = bus.b[WORD_W-1];
    ea1_d = bus.a[MAN_W +: EXP_W];
    eb1_d = bus.b[MAN_W +: EXP_W];
    ma1_d = bus.a[MAN_W-1:0];
    mb1_d = bus.b[MAN_W-1:0];

    acc_d[0]  = '0;
    sign_d[0] = sa_q ^ sb_q;
    ea_d[0]   = ea1_q;
    eb_d[0]   = eb1_q;
    siga_d[0] = {|ea1_q, ma1_q};
    sigb_d[0] = {|eb1_q, mb1_q};

    for (int j = 1; j <= MUL_STAGES; j++) begin
      acc_d[j]  = acc_q[j-1] +
                  (PROD_W'(PP_W'(siga_q[j-1]) *
                           PP_W'(sigb_q[j-1][CHUNK_W*(j-1) +: CHUNK_W]))
                   << (CHUNK_W*(j-1)));
      sign_d[j] = sign_q[j-1];
      ea_d[j]   = ea_q[j-1];
      eb_d[j]   = eb_q[j-1];
    end
    for (int j = 1; j < MUL_STAGES; j++) begin
      siga_d[j] = siga_q[j-1];
      sigb_d[j] = sigb_q[j-1];
    end

    // Normalise on product bit 47, truncating the mantissa.
    exp_sum  = ESUM_W'(ea_q[MUL_STAGES]) + ESUM_W'(eb_q[MUL_STAGES]);
    sign_f_d = sign_q[MUL_STAGES];
    if (acc_q[MUL_STAGES][PROD_W-1]) begin
      exp_f_d = EXP_W'(exp_sum - ESUM_W'(126));
      man_f_d = acc_q[MUL_STAGES][PROD_W-2 -: MAN_W];
    end else begin
      exp_f_d = EXP_W'(exp_sum - ESUM_W'(127));
      man_f_d = acc_q[MUL_STAGES][PROD_W-3 -: MAN_W];
    end

`ifdef FP32_MUL_SPECIAL_CASES_EN
    rawa1_d   = bus.a;
    rawb1_d   = bus.b;
    rawa_d[0] = rawa1_q;
    rawb_d[0] = rawb1_q;
    for (int j = 1; j <= MUL_STAGES; j++) begin
      rawa_d[j] = rawa_q[j-1];
      rawb_d[j] = rawb_q[j-1];
    end
    rawa_f_d = rawa_q[MUL_STAGES];
    rawb_f_d = rawb_q[MUL_STAGES];
`endif
  end

  // Pipeline registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      sa_q  <= 1'b0;
      sb_q  <= 1'b0;
      ea1_q <= '0;
      eb1_q <= '0;
      ma1_q <= '0;
      mb1_q <= '0;
      for (int j = 0; j <= MUL_STAGES; j++) begin
        acc_q[j]  <= '0;
        sign_q[j] <= 1'b0;
        ea_q[j]   <= '0;
        eb_q[j]   <= '0;
      end
      for (int j = 0; j < MUL_STAGES; j++) begin
        siga_q[j] <= '0;
        sigb_q[j] <= '0;
      end
      sign_f_q <= 1'b0;
      exp_f_q  <= '0;
      man_f_q  <= '0;
`ifdef FP32_MUL_SPECIAL_CASES_EN
      rawa1_q <= '0;
      rawb1_q <= '0;
      for (int j = 0; j <= MUL_STAGES; j++) begin
        rawa_q[j] <= '0;
        rawb_q[j] <= '0;
      end
      rawa_f_q <= '0;
      rawb_f_q <= '0;
`endif
    end else begin
      sa_q  <= sa_d;
      sb_q  <= sb_d;
      ea1_q <= ea1_d;
      eb1_q <= eb1_d;
      ma1_q <= ma1_d;
      mb1_q <= mb1_d;
      for (int j = 0; j <= MUL_STAGES; j++) begin
        acc_q[j]  <= acc_d[j];
        sign_q[j] <= sign_d[j];
        ea_q[j]   <= ea_d[j];
        eb_q[j]   <= eb_d[j];
      end
      for (int j = 0; j < MUL_STAGES; j++) begin
        siga_q[j] <= siga_d[j];
        sigb_q[j] <= sigb_d[j];
      end
      sign_f_q <= sign_f_d;
      exp_f_q  <= exp_f_d;
      man_f_q  <= man_f_d;
`ifdef FP32_MUL_SPECIAL_CASES_EN
      rawa1_q <= rawa1_d;
      rawb1_q <= rawb1_d;
      for (int j = 0; j <= MUL_STAGES; j++) begin
        rawa_q[j] <= rawa_d[j];
        rawb_q[j] <= rawb_d[j];
      end
      rawa_f_q <= rawa_f_d;
      rawb_f_q <= rawb_f_d;
`endif
    end
  end

`ifdef FP32_MUL_SPECIAL_CASES_EN
  logic nan_c, inf_c, zero_c;

  // Output override priority: NaN, then Inf (always positive), then exact +0.
  always_comb begin
    nan_c  = (&rawa_f_q[MAN_W +: EXP_W] && |rawa_f_q[MAN_W-1:0]) ||
             (&rawb_f_q[MAN_W +: EXP_W] && |rawb_f_q[MAN_W-1:0]);
    inf_c  = &rawa_f_q[MAN_W +: EXP_W] || &rawb_f_q[MAN_W +: EXP_W];
    zero_c = (rawa_f_q == '0) || (rawb_f_q == '0);
    if (nan_c) begin
      bus.out = 32'h7F80_0001;
    end else if (inf_c) begin
      bus.out = 32'h7F80_0000;
    end else if (zero_c) begin
      bus.out = '0;
    end else begin
      bus.out = {sign_f_q, exp_f_q, man_f_q};
    end
  end
`else
  assign bus.out = {sign_f_q, exp_f_q, man_f_q};
`endif

endmodule

// File: tb/tb_fp32_pipe_mul.sv
// Directed bench for fp32_pipe_mul; expected values follow the build option.
module tb_fp32_pipe_mul;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  fp32_pipe_mul_if bus ();

  fp32_pipe_mul dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  localparam logic [31:0] A_ZERO  = 32'h0000_0000;
  localparam logic [31:0] A_NZERO = 32'h8000_0000;
  localparam logic [31:0] A_FIVE  = 32'h40A0_0000;
  localparam logic [31:0] A_FOUR  = 32'h4080_0000;
  localparam logic [31:0] A_NAN   = 32'h7F80_0001;
  localparam logic [31:0] A_QNAN  = 32'h7FC0_0000;
  localparam logic [31:0] A_INF   = 32'h7F80_0000;
  localparam logic [31:0] A_1234  = 32'h3F9D_F3B6;
  localparam logic [31:0] A_M1000 = 32'hC47A_0000;

  localparam logic [31:0] E_5X4   = 32'h41A0_0000;
  localparam logic [31:0] E_1234  = 32'hC49A_3FFF;
  localparam logic [31:0] E_NZ5   = 32'h8100_0000;
`ifdef FP32_MUL_SPECIAL_CASES_EN
  localparam logic [31:0] E_FLUSH = 32'h0000_0000;
  localparam logic [31:0] E_Z5    = 32'h0000_0000;
  localparam logic [31:0] E_ZNAN  = 32'h7F80_0001;
  localparam logic [31:0] E_ZINF  = 32'h7F80_0000;
  localparam logic [31:0] E_QNAN5 = 32'h7F80_0001;
  localparam logic [31:0] E_Z0    = 32'h0000_0000;
`else
  localparam logic [31:0] E_FLUSH = 32'h4080_0000;
  localparam logic [31:0] E_Z5    = 32'h0100_0000;
  localparam logic [31:0] E_ZNAN  = 32'h4000_0000;
  localparam logic [31:0] E_ZINF  = 32'h4000_0000;
  localparam logic [31:0] E_QNAN5 = 32'h00F0_0000;
  localparam logic [31:0] E_Z0    = 32'h4080_0000;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic put(input logic [31:0] va, input logic [31:0] vb);
    bus.a = va;
    bus.b = vb;
  endtask

  task automatic chk(input string tag, input logic [31:0] exp);
    n_tests++;
    assert (bus.out === exp) else begin
      n_fail++;
      $error("FAIL %s: out=%h expected=%h", tag, bus.out, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    put(A_ZERO, A_ZERO);
    tick(3);
    chk("reset_held", 32'h0000_0000);

    // Release with 5 x 4 applied; flush values until exactly edge 11.
    reset = 1'b0;
    put(A_FIVE, A_FOUR);
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      chk($sformatf("flush_%0d", k), E_FLUSH);
    end
    tick(1);
    chk("5x4_latency", E_5X4);

    put(A_ZERO, A_FIVE);   tick(11); chk("0x5", E_Z5);
    put(A_ZERO, A_NAN);    tick(11); chk("0xNaN", E_ZNAN);
    put(A_ZERO, A_INF);    tick(11); chk("0xInf", E_ZINF);
    put(A_1234, A_M1000);  tick(11); chk("1.234x-1000", E_1234);
    put(A_NZERO, A_FIVE);  tick(11); chk("neg0x5", E_NZ5);
    put(A_QNAN, A_FIVE);   tick(11); chk("qNaNx5", E_QNAN5);

    // Four pairs on consecutive edges come out on consecutive edges, in order.
    put(A_ZERO, A_FIVE);  tick(1);
    put(A_ZERO, A_NAN);   tick(1);
    put(A_1234, A_M1000); tick(1);
    put(A_FIVE, A_FOUR);  tick(1);
    tick(6);
    chk("stream_pre", E_QNAN5);
    tick(1); chk("stream_0", E_Z5);
    tick(1); chk("stream_1", E_ZNAN);
    tick(1); chk("stream_2", E_1234);
    tick(1); chk("stream_3", E_5X4);

    // One-edge reset while the stream is in flight flushes everything.
    put(A_1234, A_M1000); tick(1);
    put(A_FIVE, A_FOUR);  tick(1);
    put(A_ZERO, A_NAN);   tick(1);
    reset = 1'b1;
    put(A_ZERO, A_ZERO);
    tick(1);
    chk("mid_reset", 32'h0000_0000);
    reset = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      chk($sformatf("reflush_%0d", k), E_FLUSH);
    end
    tick(1);
    chk("0x0_after_reset", E_Z0);

    put(A_1234, A_M1000);
    tick(11);
    chk("recover", E_1234);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
